lcd_val_sched: RTL and testbench
================================

Name: lcd_val_sched

Overview:
- Frame-synchronous scheduler that feeds the value, sign and mux inputs of the LCD character display path.
- Accepts temperature and humidity samples from two producers through valid/ready handshakes and holds each in a shadow register.
- Alternates the displayed item every FRAMES_PER_ITEM frames.
- Updates display outputs only at a frame boundary, so a frame never shows a half-updated value; also flags sources whose data has gone stale.

Parameters:
- DATA_W, 20, width of value (binary, pre-BCD)
- FRAMES_PER_ITEM, 120, frames each item stays on screen (>=1)
- TIMEOUT_CYC, 150_000_000, cycles without an accepted sample before a source is flagged stale (3 s at 50 MHz)
- CNT_W, 28, width of the staleness counters (must hold TIMEOUT_CYC)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- t_valid  in  1  temperature sample valid
- t_ready  out  1  temperature sample accepted when t_valid && t_ready
- t_data  in  DATA_W  temperature magnitude
- t_sign  in  1  temperature sign (1 = negative)
- h_valid  in  1  humidity sample valid
- h_ready  out  1  humidity handshake ready
- h_data  in  DATA_W  humidity value
- lcd_vs  in  1  LCD vertical sync (asynchronous to sys_clk)
- disp_data  out  DATA_W  value to display path
- disp_sign  out  1  sign to display path
- disp_mux  out  1  0 = temperature label, 1 = humidity label
- t_stale  out  1  temperature source stale
- h_stale  out  1  humidity source stale

Behaviour:
- Reset values:
  - t_ready = h_ready = 1
  - disp_data = 0, disp_sign = 0, disp_mux = 0
  - t_stale = h_stale = 1
  - shadows = 0, has_t = has_h = 0
  - frame counter = 0, state IDLE
- Frame tick:
  - lcd_vs passes through a 2-flop synchroniser, then rising-edge detection.
  - frame_tick is a 1-cycle pulse, 3 sys_clk after the raw edge.
- Handshake:
  - t_ready = h_ready = ~frame_tick.
  - On accept: the channel shadow loads data (and sign for T), has_x is set, the staleness counter clears to 0, and stale clears on the next cycle.
  - A valid held across a frame_tick cycle is accepted the following cycle.
  - Back-to-back accepts are allowed; the last accepted sample before a tick wins.
- Staleness:
  - The per-channel counter increments every cycle and saturates at TIMEOUT_CYC.
  - stale = (counter == TIMEOUT_CYC).
  - Stale has no effect on scheduling.
- FSM states: IDLE, SHOW_T, SHOW_H. All transitions happen only on frame_tick.
  - IDLE: go to SHOW_T if has_t, else SHOW_H if has_h, else stay. The frame counter is held at 0.
  - SHOW_T / SHOW_H: the frame counter increments on each tick. When the counter == FRAMES_PER_ITEM-1 it wraps to 0 and the FSM moves to the other state only if that channel's has_x = 1; otherwise it stays.
  - FRAMES_PER_ITEM = 1 switches every frame.
- Display load, same cycle as the frame_tick that evaluates the FSM, using next-state. Outputs are registered and valid 1 cycle after frame_tick.
  - SHOW_T: disp_data = t shadow, disp_sign = t_sign shadow, disp_mux = 0.
  - SHOW_H: disp_data = h shadow, disp_sign = 0, disp_mux = 1.
  - IDLE: outputs unchanged (reset values).
- Outputs remain constant between ticks, even when a new sample is accepted mid-frame. A new sample appears at the next tick.
- Reset asserted mid-frame returns all state to reset values on the next clock; a pending vs edge in the synchroniser is discarded.

Decomposition:
- Package lcd_sched_pkg:
  - state enum {IDLE, SHOW_T, SHOW_H}
  - constants MUX_TEMP = 1'b0, MUX_HUM = 1'b1
  - default DATA_W
- Sub-module vs_edge_sync (2-flop sync + rising-edge pulse, sys_clk / sys_rst). It is reusable by other frame-synchronous blocks.

Test Plan (FRAMES_PER_ITEM = 3, TIMEOUT_CYC = 100):
- Reset only, 5 vs pulses → state stays IDLE; disp_data = 0, disp_mux = 0; t_stale = h_stale = 1.
- Accept t_data = 235, t_sign = 1, then one vs edge → 4 cycles after the raw edge, disp_data = 235, disp_sign = 1, disp_mux = 0; t_stale = 0 one cycle after accept.
- T = 235 and H = 60 loaded, 7 vs pulses → mux sequence per tick: 0,0,0,1,1,1,0; disp_data tracks 235/60; disp_sign = 0 while H is shown.
- Only T loaded, 6 ticks → disp_mux stays 0 throughout (no switch to an empty channel).
- t_valid asserted during the frame_tick cycle → t_ready = 0 that cycle, accepted next cycle; disp_data changes only at the following tick.
- No accept for 100 cycles after a T sample → t_stale rises at exactly cycle 100. Assert sys_rst mid-frame → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD value scheduler and its helpers.
// The scheduler state, display-mux label encoding and default datapath width live here.
package lcd_sched_pkg;

  localparam int DEFAULT_DATA_W = 20;

  localparam logic MUX_TEMP = 1'b0;
  localparam logic MUX_HUM  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_T = 2'd1,
    SHOW_H = 2'd2
  } sched_state_t;

endpackage

// File: rtl/lcd_val_sched_vs_edge_sync.sv
// Brings an asynchronous vertical-sync line into the sys_clk domain and emits a
// registered one-cycle pulse per rising edge, three sys_clk after the raw edge.
module vs_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic vs_async,
  output logic frame_tick
);

  logic vs_meta;
  logic vs_sync;
  logic vs_sync_d;

  // Reset flushes the whole chain, so an edge caught mid-synchroniser is dropped.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_sync_d  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= vs_async;
      vs_sync    <= vs_meta;
      vs_sync_d  <= vs_sync;
      frame_tick <= vs_sync & ~vs_sync_d;
    end
  end

endmodule

// File: rtl/lcd_val_sched.sv
// Frame-synchronous scheduler feeding value/sign/label to the LCD character path.
// Samples are shadowed on accept and only reach the display at a frame tick.
module lcd_val_sched
  import lcd_sched_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int FRAMES_PER_ITEM = 120,
  parameter int TIMEOUT_CYC     = 150_000_000,
  parameter int CNT_W           = 28
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              t_valid,
  output logic              t_ready,
  input  logic [DATA_W-1:0] t_data,
  input  logic              t_sign,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [DATA_W-1:0] h_data,
  input  logic              lcd_vs,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_sign,
  output logic              disp_mux,
  output logic              t_stale,
  output logic              h_stale
);

  localparam int FCNT_W = (FRAMES_PER_ITEM > 1) ? $clog2(FRAMES_PER_ITEM) : 1;
  localparam logic [FCNT_W-1:0] LAST_FRAME  = FCNT_W'(FRAMES_PER_ITEM - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  logic frame_tick;

  vs_edge_sync u_vs_edge_sync (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .vs_async  (lcd_vs),
    .frame_tick(frame_tick)
  );

  // Refusing samples on the tick cycle keeps shadows stable while the display loads.
  assign t_ready = ~frame_tick;
  assign h_ready = ~frame_tick;

  logic t_accept;
  logic h_accept;

  assign t_accept = t_valid & t_ready;
  assign h_accept = h_valid & h_ready;

  logic [DATA_W-1:0] t_shadow;
  logic              t_sign_shadow;
  logic [DATA_W-1:0] h_shadow;
  logic              has_t;
  logic              has_h;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      t_shadow      <= '0;
      t_sign_shadow <= 1'b0;
      has_t         <= 1'b0;
    end else if (t_accept) begin
      t_shadow      <= t_data;
      t_sign_shadow <= t_sign;
      has_t         <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      h_shadow <= '0;
      has_h    <= 1'b0;
    end else if (h_accept) begin
      h_shadow <= h_data;
      has_h    <= 1'b1;
    end
  end

  // Age counters start saturated so a source with no data yet reads as stale.
  logic [CNT_W-1:0] t_age;
  logic [CNT_W-1:0] h_age;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      t_age <= TIMEOUT_VAL;
    end else if (t_accept) begin
      t_age <= '0;
    end else if (t_age != TIMEOUT_VAL) begin
      t_age <= t_age + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      h_age <= TIMEOUT_VAL;
    end else if (h_accept) begin
      h_age <= '0;
    end else if (h_age != TIMEOUT_VAL) begin
      h_age <= h_age + 1'b1;
    end
  end

  assign t_stale = (t_age == TIMEOUT_VAL);
  assign h_stale = (h_age == TIMEOUT_VAL);

  sched_state_t      state;
  sched_state_t      state_nx;
  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] frame_cnt_nx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  // An item only hands over to a channel that has data; otherwise it keeps the screen.
  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          frame_cnt_nx = '0;
          if (has_t) begin
            state_nx = SHOW_T;
          end else if (has_h) begin
            state_nx = SHOW_H;
          end
        end
        SHOW_T: begin
          if (frame_cnt == LAST_FRAME) begin
            frame_cnt_nx = '0;
            if (has_h) begin
              state_nx = SHOW_H;
            end
          end else begin
            frame_cnt_nx = frame_cnt + 1'b1;
          end
        end
        SHOW_H: begin
          if (frame_cnt == LAST_FRAME) begin
            frame_cnt_nx = '0;
            if (has_t) begin
              state_nx = SHOW_T;
            end
          end else begin
            frame_cnt_nx = frame_cnt + 1'b1;
          end
        end
        default: begin
          state_nx     = IDLE;
          frame_cnt_nx = '0;
        end
      endcase
    end
  end

  // Loading from next-state makes the new item visible one cycle after the tick.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      disp_data <= '0;
      disp_sign <= 1'b0;
      disp_mux  <= MUX_TEMP;
    end else if (frame_tick) begin
      case (state_nx)
        SHOW_T: begin
          disp_data <= t_shadow;
          disp_sign <= t_sign_shadow;
          disp_mux  <= MUX_TEMP;
        end
        SHOW_H: begin
          disp_data <= h_shadow;
          disp_sign <= 1'b0;
          disp_mux  <= MUX_HUM;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_val_sched.sv
// Self-checking bench for lcd_val_sched: constant vector table, hand-written corner
// sequences and a randomized run, all shadowed by a cycle-level reference model.
module tb_lcd_val_sched;

  localparam int DATA_W  = 20;
  localparam int FPI     = 3;
  localparam int TIMEOUT = 100;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              t_valid = 1'b0;
  logic              t_ready;
  logic [DATA_W-1:0] t_data  = '0;
  logic              t_sign  = 1'b0;
  logic              h_valid = 1'b0;
  logic              h_ready;
  logic [DATA_W-1:0] h_data  = '0;
  logic              lcd_vs  = 1'b0;
  logic [DATA_W-1:0] disp_data;
  logic              disp_sign;
  logic              disp_mux;
  logic              t_stale;
  logic              h_stale;

  lcd_val_sched #(
    .DATA_W         (DATA_W),
    .FRAMES_PER_ITEM(FPI),
    .TIMEOUT_CYC    (TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .t_valid  (t_valid),
    .t_ready  (t_ready),
    .t_data   (t_data),
    .t_sign   (t_sign),
    .h_valid  (h_valid),
    .h_ready  (h_ready),
    .h_data   (h_data),
    .lcd_vs   (lcd_vs),
    .disp_data(disp_data),
    .disp_sign(disp_sign),
    .disp_mux (disp_mux),
    .t_stale  (t_stale),
    .h_stale  (h_stale)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which item is on screen and for how many ticks, plus sample ages.
  localparam int NONE = 0;
  localparam int TEMP = 1;
  localparam int HUM  = 2;

  int                k;
  bit                tick_at[int];
  logic              vs_prev;
  int                shown;
  int                item_ticks;
  logic [DATA_W-1:0] m_t_val, m_h_val, m_disp;
  logic              m_t_sgn, m_disp_sign, m_disp_mux;
  bit                m_has_t, m_has_h;
  int                t_last, h_last;

  task automatic model_reset();
    k = 0;
    tick_at.delete();
    vs_prev = 1'b0;
    shown = NONE;
    item_ticks = 0;
    m_t_val = '0; m_h_val = '0; m_disp = '0;
    m_t_sgn = 1'b0; m_disp_sign = 1'b0; m_disp_mux = 1'b0;
    m_has_t = 1'b0; m_has_h = 1'b0;
    t_last = -1; h_last = -1;
  endtask

  task automatic advance_frame();
    if (shown == NONE) begin
      if (m_has_t) begin shown = TEMP; item_ticks = 1; end
      else if (m_has_h) begin shown = HUM; item_ticks = 1; end
    end else if (item_ticks == FPI) begin
      item_ticks = 1;
      if (shown == TEMP && m_has_h) shown = HUM;
      else if (shown == HUM && m_has_t) shown = TEMP;
    end else begin
      item_ticks++;
    end
    if (shown == TEMP) begin
      m_disp = m_t_val; m_disp_sign = m_t_sgn; m_disp_mux = 1'b0;
    end else if (shown == HUM) begin
      m_disp = m_h_val; m_disp_sign = 1'b0; m_disp_mux = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (sys_rst) begin
      model_reset();
    end else begin
      k++;
      if (tick_at.exists(k)) begin
        advance_frame();
      end else begin
        if (t_valid) begin m_t_val = t_data; m_t_sgn = t_sign; m_has_t = 1'b1; t_last = k; end
        if (h_valid) begin m_h_val = h_data; m_has_h = 1'b1; h_last = k; end
      end
      if (lcd_vs && !vs_prev) tick_at[k + 3] = 1'b1;
      vs_prev = lcd_vs;
    end
  endtask

  task automatic model_check();
    bit exp_rdy;
    bit exp_ts, exp_hs;
    exp_rdy = !tick_at.exists(k + 1);
    exp_ts  = (t_last < 0) || (k - t_last >= TIMEOUT);
    exp_hs  = (h_last < 0) || (k - h_last >= TIMEOUT);
    checkOutput("model_t_ready", 32'(t_ready), 32'(exp_rdy));
    checkOutput("model_h_ready", 32'(h_ready), 32'(exp_rdy));
    checkOutput("model_disp_data", 32'(disp_data), 32'(m_disp));
    checkOutput("model_disp_sign", 32'(disp_sign), 32'(m_disp_sign));
    checkOutput("model_disp_mux", 32'(disp_mux), 32'(m_disp_mux));
    checkOutput("model_t_stale", 32'(t_stale), 32'(exp_ts));
    checkOutput("model_h_stale", 32'(h_stale), 32'(exp_hs));
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    model_check();
  endtask

  // One raw vs pulse, then wait until the resulting display load is visible.
  task automatic do_frame();
    lcd_vs = 1'b1; step();
    lcd_vs = 1'b0; step(); step(); step();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; step(); step();
    sys_rst = 1'b0;
  endtask

  typedef struct {
    bit                ld_t;
    logic [DATA_W-1:0] t_val;
    bit                t_sgn;
    bit                ld_h;
    logic [DATA_W-1:0] h_val;
    logic [DATA_W-1:0] exp_data;
    bit                exp_sign;
    bit                exp_mux;
  } vec_t;

  function automatic vec_t mk(bit lt, int tv, bit ts, bit lh, int hv, int ed, bit es, bit em);
    vec_t v;
    v.ld_t = lt; v.t_val = DATA_W'(tv); v.t_sgn = ts;
    v.ld_h = lh; v.h_val = DATA_W'(hv);
    v.exp_data = DATA_W'(ed); v.exp_sign = es; v.exp_mux = em;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if (v.ld_t) begin
      t_valid = 1'b1; t_data = v.t_val; t_sign = v.t_sgn;
      step();
      t_valid = 1'b0;
      checkOutput("tbl_t_stale_after_accept", 32'(t_stale), 32'd0);
    end
    if (v.ld_h) begin
      h_valid = 1'b1; h_data = v.h_val;
      step();
      h_valid = 1'b0;
    end
    step(); step();
    do_frame();
    checkOutput("tbl_disp_data", 32'(disp_data), 32'(v.exp_data));
    checkOutput("tbl_disp_sign", 32'(disp_sign), 32'(v.exp_sign));
    checkOutput("tbl_disp_mux", 32'(disp_mux), 32'(v.exp_mux));
    step();
  endtask

  vec_t tbl[16];

  initial begin
    int fpos, flen;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 235, 1, 0, 0, 235, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 60, 235, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 235, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 60, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 60, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 60, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 235, 1, 0);
    tbl[12] = mk(1, 1000, 0, 0, 0, 1000, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 4242, 1000, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 4242, 0, 1);
    tbl[15] = mk(0, 0, 0, 1, 1048575, 1048575, 0, 1);

    do_reset();
    checkOutput("reset_t_ready", 32'(t_ready), 32'd1);
    checkOutput("reset_h_ready", 32'(h_ready), 32'd1);
    checkOutput("reset_disp_data", 32'(disp_data), 32'd0);
    checkOutput("reset_disp_mux", 32'(disp_mux), 32'd0);
    checkOutput("reset_t_stale", 32'(t_stale), 32'd1);
    checkOutput("reset_h_stale", 32'(h_stale), 32'd1);

    for (int i = 0; i < 16; i++) applyStimulus(tbl[i]);

    // Only temperature present: the schedule must never switch to the empty channel.
    do_reset();
    t_valid = 1'b1; t_data = DATA_W'(77); t_sign = 1'b0;
    step();
    t_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      do_frame();
      checkOutput("only_t_mux", 32'(disp_mux), 32'd0);
      checkOutput("only_t_data", 32'(disp_data), 32'd77);
    end

    // Valid presented during the tick cycle is held off one cycle.
    step();
    lcd_vs = 1'b1; step();
    lcd_vs = 1'b0; step(); step();
    t_valid = 1'b1; t_data = DATA_W'(500);
    checkOutput("tick_cycle_t_ready", 32'(t_ready), 32'd0);
    step();
    checkOutput("after_tick_t_ready", 32'(t_ready), 32'd1);
    step();
    t_valid = 1'b0;
    checkOutput("mid_frame_data_held", 32'(disp_data), 32'd77);
    step();
    do_frame();
    checkOutput("next_tick_data", 32'(disp_data), 32'd500);

    // Staleness rises exactly TIMEOUT cycles after the last accept.
    do_reset();
    t_valid = 1'b1; t_data = DATA_W'(9);
    step();
    t_valid = 1'b0;
    checkOutput("stale_clear", 32'(t_stale), 32'd0);
    repeat (TIMEOUT - 1) step();
    checkOutput("stale_one_before", 32'(t_stale), 32'd0);
    step();
    checkOutput("stale_at_timeout", 32'(t_stale), 32'd1);
    checkOutput("h_stale_never_loaded", 32'(h_stale), 32'd1);

    // Reset mid-frame with an edge still in the synchroniser.
    h_valid = 1'b1; h_data = DATA_W'(33);
    step();
    h_valid = 1'b0;
    do_frame();
    checkOutput("pre_reset_data", 32'(disp_data), 32'd9);
    lcd_vs = 1'b1; step();
    lcd_vs = 1'b0; sys_rst = 1'b1; step();
    checkOutput("mid_rst_disp_data", 32'(disp_data), 32'd0);
    checkOutput("mid_rst_disp_sign", 32'(disp_sign), 32'd0);
    checkOutput("mid_rst_disp_mux", 32'(disp_mux), 32'd0);
    checkOutput("mid_rst_t_stale", 32'(t_stale), 32'd1);
    checkOutput("mid_rst_h_stale", 32'(h_stale), 32'd1);
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("no_tick_after_rst", 32'(t_ready), 32'd1);
    end

    // Randomized traffic with quiet windows so both sources go stale and recover.
    fpos = 0;
    flen = 20;
    for (int c = 0; c < 3000; c++) begin
      lcd_vs = (fpos < 2);
      fpos++;
      if (fpos == flen) begin
        fpos = 0;
        flen = $urandom_range(12, 40);
      end
      t_valid = (c >= 800 && c < 1100) ? 1'b0 : ($urandom_range(0, 7) == 0);
      t_data  = DATA_W'($urandom);
      t_sign  = 1'($urandom);
      h_valid = (c >= 1500 && c < 1800) ? 1'b0 : ($urandom_range(0, 9) == 0);
      h_data  = DATA_W'($urandom);
      step();
    end
    t_valid = 1'b0;
    h_valid = 1'b0;
    lcd_vs  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
